// File: rtl/fp_max_reduce.sv
// rtl/fp_max_reduce.sv - min/max reduction sequencer around a shared fp_max datapath
// Streams pre-classified operands through one fp_max and returns the reduced value and sticky flags.

module fp_max (
  input  logic [1:0]  fmt,
  input  logic [2:0]  rm,
  input  logic [63:0] data1,
  input  logic [64:0] ext1,
  input  logic [9:0]  class1,
  input  logic [63:0] data2,
  input  logic [64:0] ext2,
  input  logic [9:0]  class2,
  output logic [63:0] out_data,
  output logic [4:0]  out_flags,
  output logic        nan_path
);

  localparam logic [63:0] CNAN_S = 64'h0000_0000_7fc0_0000;
  localparam logic [63:0] CNAN_D = 64'h7ff8_0000_0000_0000;

  logic        nan1;
  logic        nan2;
  logic        snan;
  logic        sign1;
  logic        sign2;
  logic [63:0] mag1;
  logic [63:0] mag2;
  logic        lt;
  logic [63:0] canon;
  logic        unused_class;

  assign unused_class = ^{class1[7:0], class2[7:0]};

  always_comb begin
    nan1     = class1[9] | class1[8];
    nan2     = class2[9] | class2[8];
    snan     = class1[8] | class2[8];
    nan_path = snan | (class1[9] & class2[9]);
    sign1    = ext1[64];
    sign2    = ext2[64];
    mag1     = ext1[63:0];
    mag2     = ext2[63:0];
    canon    = (fmt == 2'd0) ? CNAN_S : CNAN_D;
    // Sign alone orders mixed-sign pairs, so -0 sorts below +0.
    if (sign1 != sign2) begin
      lt = sign1;
    end else if (sign1) begin
      lt = mag1 > mag2;
    end else begin
      lt = mag1 < mag2;
    end
    out_flags = {snan, 4'b0000};
    out_data  = '0;
    if (rm == 3'd0 || rm == 3'd1) begin
      if (nan_path) begin
        out_data = canon;
      end else if (nan1) begin
        out_data = data2;
      end else if (nan2) begin
        out_data = data1;
      end else if (rm == 3'd0) begin
        out_data = lt ? data1 : data2;
      end else begin
        out_data = lt ? data2 : data1;
      end
    end
  end

endmodule

module fp_max_reduce #(
  parameter int LW = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start_valid,
  output logic          start_ready,
  input  logic [1:0]    start_fmt,
  input  logic [2:0]    start_rm,
  input  logic [LW-1:0] start_len,
  input  logic          elem_valid,
  output logic          elem_ready,
  input  logic [63:0]   elem_data,
  input  logic [64:0]   elem_ext,
  input  logic [9:0]    elem_class,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [63:0]   res_data,
  output logic [4:0]    res_flags,
  output logic          busy
);

  localparam logic [63:0] CNAN_S = 64'h0000_0000_7fc0_0000;
  localparam logic [63:0] CNAN_D = 64'h7ff8_0000_0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [1:0]    fmt_q;
  logic [2:0]    rm_q;
  logic [LW-1:0] remain;
  logic          first;
  logic [63:0]   acc_data;
  logic [64:0]   acc_ext;
  logic [9:0]    acc_class;
  logic [4:0]    acc_flags;

  logic          start_fire;
  logic          elem_fire;
  logic [63:0]   op1_data;
  logic [64:0]   op1_ext;
  logic [9:0]    op1_class;
  logic [63:0]   fp_data;
  logic [4:0]    fp_flags;
  logic          fp_nan_path;

  // The first element is paired with itself so op(x,x) seeds the accumulator.
  assign op1_data  = first ? elem_data  : acc_data;
  assign op1_ext   = first ? elem_ext   : acc_ext;
  assign op1_class = first ? elem_class : acc_class;

  fp_max u_fp_max (
    .fmt       (fmt_q),
    .rm        (rm_q),
    .data1     (op1_data),
    .ext1      (op1_ext),
    .class1    (op1_class),
    .data2     (elem_data),
    .ext2      (elem_ext),
    .class2    (elem_class),
    .out_data  (fp_data),
    .out_flags (fp_flags),
    .nan_path  (fp_nan_path)
  );

  assign start_fire = start_valid & start_ready;
  assign elem_fire  = elem_valid & elem_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    start_ready = 1'b0;
    elem_ready  = 1'b0;
    res_valid   = 1'b0;
    res_data    = '0;
    res_flags   = '0;
    busy        = 1'b1;
    case (state)
      IDLE: begin
        start_ready = 1'b1;
        busy        = 1'b0;
        if (start_valid) begin
          state_next = (start_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        elem_ready = 1'b1;
        if (elem_valid && remain == LW'(1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        res_valid = 1'b1;
        res_data  = acc_data;
        res_flags = acc_flags;
        if (res_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fmt_q     <= '0;
      rm_q      <= '0;
      remain    <= '0;
      first     <= 1'b0;
      acc_data  <= '0;
      acc_ext   <= '0;
      acc_class <= '0;
      acc_flags <= '0;
    end else if (start_fire) begin
      fmt_q     <= start_fmt;
      rm_q      <= start_rm;
      remain    <= start_len;
      first     <= 1'b1;
      acc_ext   <= '0;
      acc_class <= '0;
      acc_flags <= '0;
      if (start_len == '0) begin
        acc_data <= (start_fmt == 2'd0) ? CNAN_S : CNAN_D;
      end else begin
        acc_data <= '0;
      end
    end else if (elem_fire) begin
      remain    <= remain - LW'(1);
      first     <= 1'b0;
      acc_flags <= acc_flags | fp_flags;
      if (fp_nan_path) begin
        acc_data  <= (fmt_q == 2'd0) ? CNAN_S : CNAN_D;
        acc_ext   <= '0;
        acc_class <= 10'h200;
      end else if (fp_data == elem_data) begin
        acc_data  <= elem_data;
        acc_ext   <= elem_ext;
        acc_class <= elem_class;
      end
    end
  end

endmodule

// File: tb/tb_fp_max_reduce.sv
// tb/tb_fp_max_reduce.sv - table-driven bench for fp_max_reduce
// Directed reductions with hand-computed results, plus reset and backpressure sequences.

module tb_fp_max_reduce;

  logic        clock;
  logic        reset;
  logic        start_valid;
  logic        start_ready;
  logic [1:0]  start_fmt;
  logic [2:0]  start_rm;
  logic [7:0]  start_len;
  logic        elem_valid;
  logic        elem_ready;
  logic [63:0] elem_data;
  logic [64:0] elem_ext;
  logic [9:0]  elem_class;
  logic        res_valid;
  logic        res_ready;
  logic [63:0] res_data;
  logic [4:0]  res_flags;
  logic        busy;

  int passed;
  int total;

  fp_max_reduce #(.LW(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .start_fmt   (start_fmt),
    .start_rm    (start_rm),
    .start_len   (start_len),
    .elem_valid  (elem_valid),
    .elem_ready  (elem_ready),
    .elem_data   (elem_data),
    .elem_ext    (elem_ext),
    .elem_class  (elem_class),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_flags   (res_flags),
    .busy        (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]       fmt;
    logic [2:0]       rm;
    logic [7:0]       len;
    logic [3:0][63:0] d;
    logic [63:0]      exp_data;
    logic [4:0]       exp_flags;
    int               exp_lat;
    bit               gap;
    int               hold;
  } vec_t;

  vec_t vecs [11];

  function automatic vec_t mkv(logic [1:0] f, logic [2:0] r, logic [7:0] n,
                               logic [63:0] d0, logic [63:0] d1, logic [63:0] d2, logic [63:0] d3,
                               logic [63:0] ed, logic [4:0] ef, int lat, bit g, int h);
    vec_t v;
    v.fmt = f; v.rm = r; v.len = n;
    v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
    v.exp_data = ed; v.exp_flags = ef; v.exp_lat = lat; v.gap = g; v.hold = h;
    return v;
  endfunction

  function automatic logic [64:0] mk_ext(logic [1:0] f, logic [63:0] d);
    if (f == 2'd0) return {d[31], 33'd0, d[30:0]};
    return {d[63], 1'b0, d[62:0]};
  endfunction

  function automatic logic [9:0] mk_cls(logic [1:0] f, logic [63:0] d);
    logic nan;
    logic quiet;
    if (f == 2'd0) begin
      nan   = (d[30:23] == 8'hff) && (d[22:0] != 23'd0);
      quiet = d[22];
    end else begin
      nan   = (d[62:52] == 11'h7ff) && (d[51:0] != 52'd0);
      quiet = d[51];
    end
    return {nan & quiet, nan & ~quiet, 8'd0};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic drive_elem(input logic [1:0] f, input logic [63:0] d);
    elem_data  = d;
    elem_ext   = mk_ext(f, d);
    elem_class = mk_cls(f, d);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, " start_ready"}, 64'(start_ready), 64'd1);
    chk({tag, " busy"}, 64'(busy), 64'd0);
    chk({tag, " res_valid"}, 64'(res_valid), 64'd0);
    chk({tag, " elem_ready"}, 64'(elem_ready), 64'd0);
    chk({tag, " res_data"}, res_data, 64'd0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int  lat;
    int  k;
    int  er_cnt;
    bit  done;
    bit  take;
    string tag;
    tag = $sformatf("vec%0d", idx);
    @(negedge clock);
    chk({tag, " start_ready"}, 64'(start_ready), 64'd1);
    start_valid = 1'b1;
    start_fmt   = v.fmt;
    start_rm    = v.rm;
    start_len   = v.len;
    elem_valid  = 1'b1;
    drive_elem(v.fmt, v.d[0]);
    @(posedge clock);
    #1 start_valid = 1'b0;
    lat = 1; k = 0; er_cnt = 0; done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clock);
      if (res_valid) begin
        done = 1'b1;
      end else begin
        drive_elem(v.fmt, v.d[(k < 4) ? k : 3]);
        elem_valid = !(v.gap && (c % 2 == 1));
        if (elem_ready) er_cnt++;
        take = elem_ready && elem_valid;
        @(posedge clock);
        #1;
        if (take) k++;
        lat++;
      end
    end
    chk({tag, " res_valid seen"}, 64'(done), 64'd1);
    chk({tag, " latency"}, 64'(lat), 64'(v.exp_lat));
    chk({tag, " consumed"}, 64'(k), 64'(v.len));
    chk({tag, " elem_ready cycles"}, 64'(er_cnt), 64'(v.exp_lat - 1));
    chk({tag, " res_data"}, res_data, v.exp_data);
    chk({tag, " res_flags"}, 64'(res_flags), 64'(v.exp_flags));
    elem_valid = 1'b1;
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clock);
      chk({tag, " hold res_valid"}, 64'(res_valid), 64'd1);
      chk({tag, " hold res_data"}, res_data, v.exp_data);
      chk({tag, " hold elem_ready"}, 64'(elem_ready), 64'd0);
      chk({tag, " hold start_ready"}, 64'(start_ready), 64'd0);
    end
    elem_valid = 1'b0;
    @(negedge clock);
    res_ready = 1'b1;
    @(posedge clock);
    #1 res_ready = 1'b0;
    @(negedge clock);
    check_idle({tag, " after result"});
  endtask

  initial begin
    passed = 0; total = 0;
    reset = 1'b1; start_valid = 1'b0; start_fmt = 2'd0; start_rm = 3'd0; start_len = 8'd0;
    elem_valid = 1'b0; elem_data = '0; elem_ext = '0; elem_class = '0; res_ready = 1'b0;

    vecs[0]  = mkv(2'd1, 3'd1, 8'd3, 64'h3ff0000000000000, 64'h4008000000000000, 64'hc000000000000000, 64'd0,
                   64'h4008000000000000, 5'h00, 4, 1'b0, 0);
    vecs[1]  = mkv(2'd1, 3'd0, 8'd2, 64'h0000000000000000, 64'h8000000000000000, 64'd0, 64'd0,
                   64'h8000000000000000, 5'h00, 3, 1'b0, 0);
    vecs[2]  = mkv(2'd0, 3'd1, 8'd3, 64'h3f800000, 64'h7f800001, 64'h40000000, 64'd0,
                   64'h0000000040000000, 5'h10, 4, 1'b0, 0);
    vecs[3]  = mkv(2'd0, 3'd1, 8'd2, 64'h7fc00001, 64'h7fc00001, 64'd0, 64'd0,
                   64'h000000007fc00000, 5'h00, 3, 1'b0, 0);
    vecs[4]  = mkv(2'd1, 3'd0, 8'd0, 64'd0, 64'd0, 64'd0, 64'd0,
                   64'h7ff8000000000000, 5'h00, 1, 1'b0, 0);
    vecs[5]  = mkv(2'd0, 3'd0, 8'd0, 64'd0, 64'd0, 64'd0, 64'd0,
                   64'h000000007fc00000, 5'h00, 1, 1'b0, 0);
    vecs[6]  = mkv(2'd1, 3'd0, 8'd4, 64'h4014000000000000, 64'hbff8000000000000, 64'hc008000000000000, 64'h4000000000000000,
                   64'hc008000000000000, 5'h00, 8, 1'b1, 5);
    vecs[7]  = mkv(2'd1, 3'd1, 8'd2, 64'hbff0000000000000, 64'hbfe0000000000000, 64'd0, 64'd0,
                   64'hbfe0000000000000, 5'h00, 3, 1'b0, 0);
    vecs[8]  = mkv(2'd0, 3'd0, 8'd2, 64'h7fc00001, 64'hbf800000, 64'd0, 64'd0,
                   64'h00000000bf800000, 5'h00, 3, 1'b0, 0);
    vecs[9]  = mkv(2'd1, 3'd2, 8'd2, 64'h3ff0000000000000, 64'h4000000000000000, 64'd0, 64'd0,
                   64'h0000000000000000, 5'h00, 3, 1'b0, 0);
    vecs[10] = mkv(2'd1, 3'd1, 8'd1, 64'h7ff0000000000001, 64'd0, 64'd0, 64'd0,
                   64'h7ff8000000000000, 5'h10, 2, 1'b0, 0);

    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check_idle("reset");

    for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

    // Reset in the middle of a run discards the partial reduction.
    @(negedge clock);
    start_valid = 1'b1; start_fmt = 2'd1; start_rm = 3'd1; start_len = 8'd5;
    @(posedge clock);
    #1 start_valid = 1'b0;
    elem_valid = 1'b1;
    drive_elem(2'd1, 64'h3ff0000000000000);
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("midrun busy", 64'(busy), 64'd1);
    chk("midrun elem_ready", 64'(elem_ready), 64'd1);
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    elem_valid = 1'b0;
    @(negedge clock);
    check_idle("midrun reset");

    run_vec(vecs[0], 11);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
